// File: rtl/ct_spsram_128x144_arb_ctrl_pkg.sv
// rtl/ct_spsram_128x144_arb_ctrl_pkg.sv - shared types and constants for the 128x144 SP-SRAM arbiter
package ct_spsram_128x144_arb_ctrl_pkg;

  localparam int SRAM_DEPTH  = 128;
  localparam int SRAM_DATA_W = 144;

  // Active-low per-bit write enable: all ones masks every bit.
  localparam logic [SRAM_DATA_W-1:0] SRAM_WEN_OFF = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// rtl/ct_spsram_rr_arb2.sv - 2-way round-robin arbiter (write vs read), pointer flips only on contested grants
module ct_spsram_rr_arb2
  import ct_spsram_128x144_arb_ctrl_pkg::*;
(
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       en,
  input  logic       wr_vld,
  input  logic       rd_vld,
  output logic [1:0] gnt
);

  logic ptr_rd_q;
  logic contested;

  assign contested = en & wr_vld & rd_vld;

  always_comb begin
    gnt = GNT_NONE;
    if (en) begin
      if (wr_vld && rd_vld) gnt = ptr_rd_q ? GNT_RD : GNT_WR;
      else if (rd_vld)      gnt = GNT_RD;
      else if (wr_vld)      gnt = GNT_WR;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)      ptr_rd_q <= 1'b1;
    else if (contested) ptr_rd_q <= ~ptr_rd_q;
  end

endmodule

// File: rtl/ct_spsram_128x144_arb_ctrl.sv
// rtl/ct_spsram_128x144_arb_ctrl.sv - 128x144 SP-SRAM sequencer/arbiter
// Define CT_SPSRAM_ARB_INIT_EN to zero all entries with a sweep after reset.
module ct_spsram_128x144_arb_ctrl
  import ct_spsram_128x144_arb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  wr_req_vld,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [DATA_WIDTH-1:0] wr_req_mask,
  output logic                  wr_req_rdy,
  input  logic                  rd_req_vld,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_rdy,
  output logic                  rd_rsp_vld,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH:0] INIT_LAST = (ADDR_WIDTH+1)'(SRAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic   [1:0]          gnt;
  logic                  run_en, init_wr, init_last;
  logic   [ADDR_WIDTH:0] init_cnt_q;
  logic                  rd_pend_q, rsp_vld_q, init_done_q;
  logic   [DATA_WIDTH-1:0] rsp_hold_q;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)    init_cnt_q <= '0;
    else if (init_wr) init_cnt_q <= init_cnt_q + 1'b1;
  end
`else
  localparam state_e RESET_STATE = ST_RUN;

  assign init_cnt_q = '0;
`endif

  assign init_last = (init_cnt_q == INIT_LAST);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= RESET_STATE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    init_wr = 1'b0;
    run_en  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        if (init_last) state_d = ST_RUN;
      end
      ST_RUN:  run_en = 1'b1;
      default: state_d = RESET_STATE;
    endcase
  end

  ct_spsram_rr_arb2 u_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .en             (run_en),
    .wr_vld         (wr_req_vld),
    .rd_vld         (rd_req_vld),
    .gnt            (gnt)
  );

  assign wr_req_rdy = (gnt == GNT_WR);
  assign rd_req_rdy = (gnt == GNT_RD);

  // Grant in cycle T is presented to the macro in T+1; idle cycles keep A/D.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= SRAM_WEN_OFF;
      sram_a    <= '0;
      sram_d    <= '0;
    end else if (init_wr) begin
      sram_cen  <= 1'b0;
      sram_gwen <= 1'b0;
      sram_wen  <= '0;
      sram_a    <= init_cnt_q[ADDR_WIDTH-1:0];
      sram_d    <= '0;
    end else if (gnt == GNT_WR) begin
      sram_cen  <= 1'b0;
      sram_gwen <= 1'b0;
      sram_wen  <= ~wr_req_mask;
      sram_a    <= wr_req_addr;
      sram_d    <= wr_req_data;
    end else if (gnt == GNT_RD) begin
      sram_cen  <= 1'b0;
      sram_gwen <= 1'b1;
      sram_wen  <= SRAM_WEN_OFF;
      sram_a    <= rd_req_addr;
    end else begin
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= SRAM_WEN_OFF;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_hold_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      rd_pend_q   <= (gnt == GNT_RD);
      rsp_vld_q   <= rd_pend_q;
      init_done_q <= (state_q == ST_RUN);
      if (rsp_vld_q) rsp_hold_q <= sram_q;
    end
  end

  // Q is valid in the response cycle itself; the hold register keeps it afterwards.
  assign rd_rsp_vld  = rsp_vld_q;
  assign rd_rsp_data = rsp_vld_q ? sram_q : rsp_hold_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_ct_spsram_128x144_arb_ctrl.sv
// tb/tb_ct_spsram_128x144_arb_ctrl.sv - directed bench for ct_spsram_128x144_arb_ctrl with a behavioural SRAM
module tb_ct_spsram_128x144_arb_ctrl;

  logic         clk;
  logic         rst_n;
  logic         wr_req_vld;
  logic [6:0]   wr_req_addr;
  logic [143:0] wr_req_data;
  logic [143:0] wr_req_mask;
  logic         wr_req_rdy;
  logic         rd_req_vld;
  logic [6:0]   rd_req_addr;
  logic         rd_req_rdy;
  logic         rd_rsp_vld;
  logic [143:0] rd_rsp_data;
  logic         init_done;
  logic [6:0]   sram_a;
  logic         sram_cen;
  logic         sram_gwen;
  logic [143:0] sram_wen;
  logic [143:0] sram_d;
  logic [143:0] sram_q;

  logic [143:0] mem [0:127];
  int n_checks = 0;
  int n_fails  = 0;

  ct_spsram_128x144_arb_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .wr_req_vld     (wr_req_vld),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .wr_req_mask    (wr_req_mask),
    .wr_req_rdy     (wr_req_rdy),
    .rd_req_vld     (rd_req_vld),
    .rd_req_addr    (rd_req_addr),
    .rd_req_rdy     (rd_req_rdy),
    .rd_rsp_vld     (rd_rsp_vld),
    .rd_rsp_data    (rd_rsp_data),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  function automatic logic [143:0] pat(input int i);
    logic [15:0] w;
    w = 16'hA500 + 16'(i);
    return {9{w}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_req_vld = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
    rd_req_vld = 1'b0; rd_req_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (wr_req_rdy !== 1'b0 || rd_req_rdy !== 1'b0 || rd_rsp_vld !== 1'b0 || rd_rsp_data !== '0 ||
        init_done !== 1'b0 || sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== {144{1'b1}} ||
        sram_a !== 7'd0 || sram_d !== '0) begin
      n_fails++;
      $display("FAIL reset_values: rdy=%b%b rsp_vld=%b init_done=%b cen=%b gwen=%b a=%0d, required rdy=00 rsp_vld=0 init_done=0 cen=1 gwen=1 a=0",
               wr_req_rdy, rd_req_rdy, rd_rsp_vld, init_done, sram_cen, sram_gwen, sram_a);
    end
`ifdef CT_SPSRAM_ARB_INIT_EN
    wr_req_vld = 1'b1;
    rd_req_vld = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 128; k++) begin
      cyc();
      n_checks++;
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
          sram_a !== 7'(k) || init_done !== 1'b0 || (k < 127 && (wr_req_rdy !== 1'b0 || rd_req_rdy !== 1'b0))) begin
        n_fails++;
        $display("FAIL init_sweep k=%0d: a=%0d cen=%b gwen=%b init_done=%b rdy=%b%b, required a=%0d cen=0 gwen=0 init_done=0 rdy=00",
                 k, sram_a, sram_cen, sram_gwen, init_done, wr_req_rdy, rd_req_rdy, k);
      end
      if (k == 126) begin
        wr_req_vld = 1'b0;
        rd_req_vld = 1'b0;
      end
    end
    cyc();
    n_checks++;
    if (init_done !== 1'b1 || sram_cen !== 1'b1) begin
      n_fails++;
      $display("FAIL init_done_rise: init_done=%b cen=%b, required init_done=1 cen=1", init_done, sram_cen);
    end
`else
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (init_done !== 1'b1 || sram_cen !== 1'b1) begin
      n_fails++;
      $display("FAIL init_done_noinit: init_done=%b cen=%b, required init_done=1 cen=1", init_done, sram_cen);
    end
`endif
  endtask

  task automatic test_write_read();
    wr_req_vld = 1'b1; wr_req_addr = 7'd3; wr_req_data = {18{8'h5A}}; wr_req_mask = '1;
    @(negedge clk);
    n_checks++;
    if (wr_req_rdy !== 1'b1 || rd_req_rdy !== 1'b0) begin
      n_fails++;
      $display("FAIL wr_rdy: rdy=%b%b, required 10", wr_req_rdy, rd_req_rdy);
    end
    cyc();
    wr_req_vld = 1'b0;
    n_checks++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 7'd3 || sram_wen !== '0 || sram_d !== {18{8'h5A}}) begin
      n_fails++;
      $display("FAIL wr_drive: cen=%b gwen=%b a=%0d d=%h, required cen=0 gwen=0 a=3 d=5a..5a", sram_cen, sram_gwen, sram_a, sram_d);
    end
    rd_req_vld = 1'b1; rd_req_addr = 7'd3;
    @(negedge clk);
    n_checks++;
    if (rd_req_rdy !== 1'b1) begin
      n_fails++;
      $display("FAIL rd_rdy: rd_req_rdy=%b, required 1", rd_req_rdy);
    end
    cyc();
    rd_req_vld = 1'b0;
    n_checks++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_a !== 7'd3 || sram_wen !== {144{1'b1}} || rd_rsp_vld !== 1'b0) begin
      n_fails++;
      $display("FAIL rd_drive: cen=%b gwen=%b a=%0d rsp_vld=%b, required cen=0 gwen=1 a=3 rsp_vld=0", sram_cen, sram_gwen, sram_a, rd_rsp_vld);
    end
    cyc();
    n_checks++;
    if (rd_rsp_vld !== 1'b1 || rd_rsp_data !== {18{8'h5A}}) begin
      n_fails++;
      $display("FAIL rd_rsp: vld=%b data=%h, required vld=1 data=5a..5a", rd_rsp_vld, rd_rsp_data);
    end
    cyc();
    n_checks++;
    if (rd_rsp_vld !== 1'b0 || rd_rsp_data !== {18{8'h5A}} || sram_cen !== 1'b1 || sram_a !== 7'd3) begin
      n_fails++;
      $display("FAIL rd_hold: vld=%b data=%h cen=%b a=%0d, required vld=0 data=5a..5a cen=1 a=3", rd_rsp_vld, rd_rsp_data, sram_cen, sram_a);
    end
  endtask

  task automatic test_masked_write();
    wr_req_vld = 1'b1; wr_req_addr = 7'd5; wr_req_data = '0; wr_req_mask = '1;
    cyc();
    wr_req_data = '1; wr_req_mask = 144'hFF;
    cyc();
    n_checks++;
    if (sram_wen !== ~144'hFF || sram_d !== {144{1'b1}}) begin
      n_fails++;
      $display("FAIL mask_wen: wen=%h, required ~ff", sram_wen);
    end
    wr_req_mask = '0;
    cyc();
    wr_req_vld = 1'b0;
    n_checks++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== {144{1'b1}}) begin
      n_fails++;
      $display("FAIL zero_mask: cen=%b gwen=%b wen=%h, required cen=0 gwen=0 wen=all ones", sram_cen, sram_gwen, sram_wen);
    end
    rd_req_vld = 1'b1; rd_req_addr = 7'd5;
    cyc();
    rd_req_vld = 1'b0;
    cyc();
    n_checks++;
    if (rd_rsp_vld !== 1'b1 || rd_rsp_data !== 144'hFF) begin
      n_fails++;
      $display("FAIL mask_read: vld=%b data=%h, required vld=1 data=ff", rd_rsp_vld, rd_rsp_data);
    end
  endtask

  task automatic test_contention();
    logic exp_rd;
    wr_req_vld = 1'b1; wr_req_addr = 7'd20; wr_req_data = pat(20); wr_req_mask = '1;
    rd_req_vld = 1'b1; rd_req_addr = 7'd21;
    for (int i = 0; i < 8; i++) begin
      exp_rd = (i % 2 == 0);
      @(negedge clk);
      n_checks++;
      if (rd_req_rdy !== exp_rd || wr_req_rdy !== !exp_rd) begin
        n_fails++;
        $display("FAIL contention i=%0d: rdy(wr,rd)=%b%b, required %b%b", i, wr_req_rdy, rd_req_rdy, !exp_rd, exp_rd);
      end
      cyc();
    end
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b0;
    n_checks++;
    if (sram_gwen !== 1'b0 || sram_a !== 7'd20) begin
      n_fails++;
      $display("FAIL contention_last: gwen=%b a=%0d, required gwen=0 a=20", sram_gwen, sram_a);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic exp_vld;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      wr_req_vld = 1'b1; wr_req_addr = 7'(i); wr_req_data = pat(i); wr_req_mask = '1;
      cyc();
    end
    wr_req_vld = 1'b0;
    for (int c = 0; c < 12; c++) begin
      rd_req_vld  = (c < 10);
      rd_req_addr = 7'(c);
      cyc();
      exp_vld = (c >= 1 && c <= 10);
      if (rd_rsp_vld === 1'b1) pulses++;
      n_checks++;
      if (rd_rsp_vld !== exp_vld || (exp_vld && rd_rsp_data !== pat(c - 1))) begin
        n_fails++;
        $display("FAIL b2b c=%0d: vld=%b data=%h, required vld=%b data=%h", c, rd_rsp_vld, rd_rsp_data, exp_vld, pat(c - 1));
      end
    end
    rd_req_vld = 1'b0;
    n_checks++;
    if (pulses != 10) begin
      n_fails++;
      $display("FAIL b2b_count: pulses=%0d, required 10", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
`ifdef CT_SPSRAM_ARB_INIT_EN
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (61) cyc();
    n_checks++;
    if (sram_a !== 7'd60 || sram_cen !== 1'b0) begin
      n_fails++;
      $display("FAIL sweep_at_60: a=%0d cen=%b, required a=60 cen=0", sram_a, sram_cen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sram_a !== 7'd0 || sram_cen !== 1'b1 || init_done !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_sweep_reset: a=%0d cen=%b init_done=%b, required a=0 cen=1 init_done=0", sram_a, sram_cen, init_done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    n_checks++;
    if (sram_a !== 7'd0 || sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin
      n_fails++;
      $display("FAIL sweep_restart: a=%0d cen=%b gwen=%b, required a=0 cen=0 gwen=0", sram_a, sram_cen, sram_gwen);
    end
    for (int t = 0; t < 200 && init_done !== 1'b1; t++) cyc();
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fails++;
      $display("FAIL init_timeout: init_done=%b, required 1 within 200 cycles", init_done);
    end
`endif
    rd_req_vld = 1'b1; rd_req_addr = 7'd3;
    cyc();
    rd_req_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_rsp_vld !== 1'b0 || sram_cen !== 1'b1 || rd_rsp_data !== '0) begin
      n_fails++;
      $display("FAIL inflight_reset: rsp_vld=%b cen=%b, required rsp_vld=0 cen=1 data=0", rd_rsp_vld, sram_cen);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      cyc();
      if (rd_rsp_vld !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fails++;
      $display("FAIL rsp_dropped: stray rd_rsp_vld=%b after reset, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
